// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two masters.
// One transaction in flight at a time, with a sticky error flag for aborted (timed-out) transfers.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    output logic [63:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_wdata,
    output logic [63:0] m1_rdata,
    output logic        m1_ready,
    output logic        sram_read,
    output logic        sram_write,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned RW = 64;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   wdata_q, wdata_d;
    logic [RW-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic            rdy0_q, rdy0_d;
    logic            rdy1_q, rdy1_d;

    logic req0, req1, pick0, finish;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        finish  = 1'b0;
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        // On a tie, the master not served last wins.
        pick0   = req0 & (~req1 | last_q);

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = pick0 ? 2'b01 : 2'b10;
                    wr_d    = pick0 ? m0_write : m1_write;
                    rd_d    = ~(pick0 ? m0_write : m1_write);
                    addr_d  = pick0 ? m0_address : m1_address;
                    wdata_d = pick0 ? m0_wdata : m1_wdata;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (sram_ready) begin
                    rdata_d = sram_rdata;
                    finish  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (finish) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    last_d  = grant_q[1];
                    rdy0_d  = grant_q[0];
                    rdy1_d  = grant_q[1];
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
        end
    end

    assign sram_read    = rd_q;
    assign sram_write   = wr_q;
    assign sram_address = addr_q;
    assign sram_wdata   = wdata_q;
    assign m0_rdata     = rdata_q;
    assign m1_rdata     = rdata_q;
    assign m0_ready     = rdy0_q;
    assign m1_ready     = rdy1_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign timeout_err  = err_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares the single SRAM controller between the data-cache controller (master 0) and a second memory requester (master 1, e.g. instruction fetch or DMA). It sits between the requesters and the SRAM controller's read/write/ready handshake. It grants one transaction at a time using round-robin priority, and holds the command stable until the controller reports completion. It also returns read data and a one-cycle ready pulse to the granted master, and aborts a hung transaction after a programmable timeout.

## Interface
- TIMEOUT, 255, maximum BUSY cycles to wait for `sram_ready` before aborting; must be at least 1.
- CNT_W, 8, width of the timeout counter; requires `2^CNT_W > TIMEOUT`.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_read, m0_write  in  1 each  master 0 request; held high until `m0_ready`.
- m0_address, m0_wdata  in  32 each  master 0 byte address and write data.
- m0_rdata  out  64  read data; valid only in the `m0_ready` cycle.
- m0_ready  out  1  one-cycle completion pulse.
- m1_read, m1_write, m1_address, m1_wdata, m1_rdata, m1_ready: same as master 0, for master 1.
- sram_read, sram_write  out  1 each  command to the SRAM controller.
- sram_address, sram_wdata  out  32 each  latched address and write data.
- sram_rdata  in  64  controller read data; valid when `sram_ready` is high.
- sram_ready  in  1  controller completion pulse.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high in BUSY and DONE.
- timeout_err  out  1  sticky; set by any aborted transaction.

## Operation
- State machine has three states: IDLE, BUSY, DONE.
- A master's request is `read | write`. If a master asserts both, it is a write (write wins).
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one master requesting: grant that master.
  - Both requesting: grant the master not served last. The `last` register resets to 1, so master 0 wins the first tie.
  - On grant, at the same edge: latch owner, op, address and wdata; clear the timeout counter; move to BUSY.
- **BUSY**
  - `sram_read`/`sram_write` are driven from the latched op, held constant every cycle.
  - `sram_address`/`sram_wdata` are driven from the latched registers.
  - The counter increments each cycle.
  - On `sram_ready`: capture `sram_rdata` into `rdata_q`; update `last` to the owner; move to DONE.
  - If the counter reaches TIMEOUT with no `sram_ready`: set `timeout_err`, load `rdata_q` = 0, update `last`, move to DONE.
- **DONE**
  - `sram_read`/`sram_write` low.
  - The owner's `mX_ready` = 1 for this cycle only.
  - `m0_rdata = m1_rdata = rdata_q`.
  - Next state is IDLE unconditionally.
- Input changes on `mX_address`/`mX_wdata` after grant are ignored; the latched copy is used.
- A write returns `rdata_q` = the captured `sram_rdata` value; requesters ignore it.
- `timeout_err` clears only on reset.

## Timing
- Reset (`rst` = 0, asynchronous) takes effect immediately, including mid-transaction, and drops the transaction with no ready pulse.
  - State → IDLE, `last` = 1.
  - All outputs 0: `sram_read`, `sram_write`, `sram_address`, `sram_wdata`, `mX_rdata`, `mX_ready`, `grant` = 00, `busy`, `timeout_err`.
- Transaction timing, with the request first seen at IDLE edge N:
  - BUSY and command high from cycle N+1.
  - If `sram_ready` arrives in cycle N+k (k≥1), DONE occurs in cycle N+k+1 and `mX_ready` is high there.
  - Minimum latency from request to ready is 2 cycles; turnaround is 3 cycles per transaction.
- Command gap: at least 2 cycles (DONE + IDLE) with `sram_read`/`sram_write` low between transactions, which the SRAM controller requires.
- Master handshake: a master drops or changes its request at the edge ending its ready cycle. A request still high in the following IDLE cycle is treated as a new transaction.
- `sram_ready` while IDLE or DONE is ignored.
- Timeout: the abort fires at the edge where the counter equals TIMEOUT, i.e. after TIMEOUT BUSY cycles. Ready follows one cycle later.
- `grant`/`busy` are registered and stable from the BUSY cycle through the DONE cycle.

## Test plan
- **Single read:** m0_read, addr 0x0000_0400; `sram_ready` with rdata 0x1122334455667788 in the 3rd BUSY cycle → m0_ready one cycle later with that data; `grant` = 01 throughout; m1_ready stays 0.
- **Contention:** m0 and m1 both hold reads continuously for 4 transactions → service order m0, m1, m0, m1; each grant is separated by a 2-cycle command-low gap.
- **Write:** m1_write, addr 0x10, wdata 0xDEADBEEF, with `m1_address` changed after grant → `sram_address`/`sram_wdata` stay 0x10/0xDEADBEEF until `sram_ready`; m1_ready pulses once.
- **Timeout:** TIMEOUT = 4, `sram_ready` never asserted → command drops after 4 BUSY cycles; m0_ready pulses with rdata 0; `timeout_err` = 1 and stays 1 across later successful transactions.
- **Reset mid-BUSY:** assert `rst` low → all outputs 0 asynchronously; no ready pulse; after release, a pending m1 request is granted only after m0 if both request (`last` = 1).
- **Read and write together:** m0 asserts read and write simultaneously → `sram_write` = 1, `sram_read` = 0.
